// File: rtl/dff_pair_arb.sv
// Two-requester round-robin arbiter that owns a shared WIDTH-bit register (Q/Q_N).
// Optional feature macro: DFF_PAIR_ARB_TIMEOUT_EN adds an ACKW timeout and the Err port.
module dff_pair_arb #(
    parameter int WIDTH = 2
) (
    input  logic             Clk,
    input  logic             R,
    input  logic             Req1,
    input  logic             Req2,
    input  logic [1:0]       Op1,
    input  logic [1:0]       Op2,
    input  logic [WIDTH-1:0] Dat1,
    input  logic [WIDTH-1:0] Dat2,
    output logic             Ack1,
    output logic             Ack2,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Q_N,
    output logic             Busy
`ifdef DFF_PAIR_ARB_TIMEOUT_EN
    ,
    output logic             Err
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_ACKW  = 2'd2
    } state_t;

    localparam logic [1:0] OP_LOAD   = 2'b00;
    localparam logic [1:0] OP_SET    = 2'b01;
    localparam logic [1:0] OP_CLEAR  = 2'b10;
    localparam logic [1:0] OP_TOGGLE = 2'b11;

    state_t            state_q, state_d;
    logic              winner_q, winner_d;   // 0 = requester 1, 1 = requester 2
    logic              ptr_q, ptr_d;         // round-robin pointer, same encoding
    logic [1:0]        mask_q, mask_d;       // per-requester re-grant masks
    logic [1:0]        ack_q, ack_d;
    logic [WIDTH-1:0]  q_q, q_d;

    logic [1:0]        req_v;
    logic [1:0]        elig;
    logic [1:0]        mask_set;
    logic [1:0]        win_oh;
    logic              win_req;
    logic [1:0]        win_op;
    logic [WIDTH-1:0]  win_dat;

    logic              apply_ev;
    logic              abort_ev;
    logic              release_ev;
    logic              timeout_ev;

`ifdef DFF_PAIR_ARB_TIMEOUT_EN
    logic [3:0]        cnt_q, cnt_d;
    logic              err_q, err_d;
`endif

    assign req_v   = {Req2, Req1};
    assign win_oh  = {winner_q, ~winner_q};
    assign win_req = winner_q ? Req2 : Req1;
    assign win_op  = winner_q ? Op2 : Op1;
    assign win_dat = winner_q ? Dat2 : Dat1;

    // A mask is set on leaving service and clears once its Req is seen low.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_req
            assign elig[gi]   = req_v[gi] & ~mask_q[gi];
            assign mask_d[gi] = (mask_q[gi] & req_v[gi]) | mask_set[gi];
        end
    endgenerate

    always_ff @(posedge Clk) begin
        if (R) begin
            state_q  <= S_IDLE;
            winner_q <= 1'b0;
            ptr_q    <= 1'b0;
            mask_q   <= 2'b00;
            ack_q    <= 2'b00;
            q_q      <= '0;
`ifdef DFF_PAIR_ARB_TIMEOUT_EN
            cnt_q    <= 4'd0;
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            winner_q <= winner_d;
            ptr_q    <= ptr_d;
            mask_q   <= mask_d;
            ack_q    <= ack_d;
            q_q      <= q_d;
`ifdef DFF_PAIR_ARB_TIMEOUT_EN
            cnt_q    <= cnt_d;
            err_q    <= err_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        winner_d   = winner_q;
        apply_ev   = 1'b0;
        abort_ev   = 1'b0;
        release_ev = 1'b0;
        timeout_ev = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (|elig) begin
                    winner_d = (elig == 2'b11) ? ptr_q : elig[1];
                    state_d  = S_GRANT;
                end
            end
            S_GRANT: begin
                // A winner that withdrew before its GRANT edge is not acknowledged.
                if (win_req) begin
                    apply_ev = 1'b1;
                    state_d  = S_ACKW;
                end else begin
                    abort_ev = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            S_ACKW: begin
                if (!win_req) begin
                    release_ev = 1'b1;
                    state_d    = S_IDLE;
                end
`ifdef DFF_PAIR_ARB_TIMEOUT_EN
                else if (cnt_q == 4'hF) begin
                    timeout_ev = 1'b1;
                    state_d    = S_IDLE;
                end
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ptr_d    = ptr_q;
        q_d      = q_q;
        ack_d    = ack_q;
        mask_set = 2'b00;
        if (apply_ev) begin
            case (win_op)
                OP_LOAD:   q_d = win_dat;
                OP_SET:    q_d = '1;
                OP_CLEAR:  q_d = '0;
                OP_TOGGLE: q_d = ~q_q;
                default:   q_d = q_q;
            endcase
            ack_d = win_oh;
        end
        if (abort_ev) begin
            ptr_d = ~ptr_q;
        end
        if (release_ev || timeout_ev) begin
            ack_d    = 2'b00;
            ptr_d    = ~ptr_q;
            mask_set = win_oh;
        end
    end

`ifdef DFF_PAIR_ARB_TIMEOUT_EN
    // Counts completed ACKW cycles; restarts on every ACKW entry.
    always_comb begin
        cnt_d = 4'd0;
        if (state_q == S_ACKW && state_d == S_ACKW) begin
            cnt_d = cnt_q + 4'd1;
        end
        err_d = timeout_ev;
    end

    assign Err = err_q;
`endif

    assign Busy = (state_q != S_IDLE);
    assign Ack1 = ack_q[0];
    assign Ack2 = ack_q[1];
    assign Q    = q_q;
    assign Q_N  = ~q_q;

endmodule

// File: tb/tb_dff_pair_arb.sv
// Directed bench for dff_pair_arb: inputs change 1ns after a rising edge ("edge n"),
// outputs are sampled 1ns after later edges, so a request shows Q/Ack two edges later.
module tb_dff_pair_arb;

    localparam int WIDTH = 2;

    logic             Clk;
    logic             R;
    logic             Req1, Req2;
    logic [1:0]       Op1, Op2;
    logic [WIDTH-1:0] Dat1, Dat2;
    logic             Ack1, Ack2;
    logic [WIDTH-1:0] Q, Q_N;
    logic             Busy;
`ifdef DFF_PAIR_ARB_TIMEOUT_EN
    logic             Err;
`endif

    int checks   = 0;
    int failures = 0;

    dff_pair_arb #(.WIDTH(WIDTH)) dut (
        .Clk  (Clk),
        .R    (R),
        .Req1 (Req1),
        .Req2 (Req2),
        .Op1  (Op1),
        .Op2  (Op2),
        .Dat1 (Dat1),
        .Dat2 (Dat2),
        .Ack1 (Ack1),
        .Ack2 (Ack2),
        .Q    (Q),
        .Q_N  (Q_N),
        .Busy (Busy)
`ifdef DFF_PAIR_ARB_TIMEOUT_EN
        ,
        .Err  (Err)
`endif
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic test_reset;
        R = 1'b1; Req1 = 1'b0; Req2 = 1'b0;
        Op1 = 2'b00; Op2 = 2'b00; Dat1 = '0; Dat2 = '0;
        step(2);
        checks++; if (Q !== 2'b00) begin failures++; $display("FAIL reset_q: got %b expected 00", Q); end
        checks++; if (Q_N !== 2'b11) begin failures++; $display("FAIL reset_qn: got %b expected 11", Q_N); end
        checks++; if ({Ack2, Ack1} !== 2'b00) begin failures++; $display("FAIL reset_ack: got %b expected 00", {Ack2, Ack1}); end
        checks++; if (Busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", Busy); end
`ifdef DFF_PAIR_ARB_TIMEOUT_EN
        checks++; if (Err !== 1'b0) begin failures++; $display("FAIL reset_err: got %b expected 0", Err); end
`endif
        R = 1'b0;
        step(1);
        checks++; if (Busy !== 1'b0 || Q !== 2'b00) begin failures++; $display("FAIL reset_idle: busy=%b q=%b expected busy=0 q=00", Busy, Q); end
        $display("test_reset done: q=%b qn=%b busy=%b", Q, Q_N, Busy);
    endtask

    task automatic test_load;
        Req1 = 1'b1; Op1 = 2'b00; Dat1 = 2'b10;
        step(1);
        checks++; if (Busy !== 1'b1) begin failures++; $display("FAIL load_busy_grant: got %b expected 1", Busy); end
        checks++; if (Q !== 2'b00 || Ack1 !== 1'b0) begin failures++; $display("FAIL load_early: q=%b ack1=%b expected q=00 ack1=0", Q, Ack1); end
        step(1);
        checks++; if (Q !== 2'b10 || Q_N !== 2'b01) begin failures++; $display("FAIL load_q: q=%b qn=%b expected q=10 qn=01", Q, Q_N); end
        checks++; if (Ack1 !== 1'b1 || Ack2 !== 1'b0) begin failures++; $display("FAIL load_ack: ack1=%b ack2=%b expected 1 0", Ack1, Ack2); end
        // Op/Dat changes while waiting in ACKW must not reach Q.
        Op1 = 2'b11; Dat1 = 2'b01;
        step(2);
        checks++; if (Q !== 2'b10 || Ack1 !== 1'b1) begin failures++; $display("FAIL load_hold: q=%b ack1=%b expected q=10 ack1=1", Q, Ack1); end
        Req1 = 1'b0;
        step(1);
        checks++; if (Ack1 !== 1'b0 || Busy !== 1'b0) begin failures++; $display("FAIL load_release: ack1=%b busy=%b expected 0 0", Ack1, Busy); end
        step(1);
        $display("test_load done: q=%b ack1=%b busy=%b", Q, Ack1, Busy);
    endtask

    task automatic test_pair;
        R = 1'b1;
        step(1);
        R = 1'b0; Req1 = 1'b1; Req2 = 1'b1; Op1 = 2'b01; Op2 = 2'b11;
        step(2);
        checks++; if (Q !== 2'b11 || Ack1 !== 1'b1 || Ack2 !== 1'b0) begin failures++; $display("FAIL pair1_first: q=%b ack1=%b ack2=%b expected 11 1 0", Q, Ack1, Ack2); end
        Req1 = 1'b0;
        step(1);
        checks++; if (Ack1 !== 1'b0 || Ack2 !== 1'b0) begin failures++; $display("FAIL pair1_gap: ack1=%b ack2=%b expected 0 0", Ack1, Ack2); end
        step(2);
        checks++; if (Q !== 2'b00 || Ack2 !== 1'b1 || Ack1 !== 1'b0) begin failures++; $display("FAIL pair1_second: q=%b ack1=%b ack2=%b expected 00 0 1", Q, Ack1, Ack2); end
        Req2 = 1'b0;
        step(2);
        // Pointer is back on requester 1; one lone requester-2 service moves it to requester 2.
        Req2 = 1'b1; Op2 = 2'b00; Dat2 = 2'b01;
        step(2);
        checks++; if (Q !== 2'b01 || Ack2 !== 1'b1) begin failures++; $display("FAIL single2: q=%b ack2=%b expected 01 1", Q, Ack2); end
        Req2 = 1'b0;
        step(2);
        Req1 = 1'b1; Op1 = 2'b00; Dat1 = 2'b10;
        Req2 = 1'b1; Op2 = 2'b01;
        step(2);
        checks++; if (Q !== 2'b11 || Ack2 !== 1'b1 || Ack1 !== 1'b0) begin failures++; $display("FAIL pair2_first: q=%b ack1=%b ack2=%b expected 11 0 1", Q, Ack1, Ack2); end
        Req2 = 1'b0;
        step(1);
        checks++; if (Ack2 !== 1'b0 || Ack1 !== 1'b0) begin failures++; $display("FAIL pair2_gap: ack1=%b ack2=%b expected 0 0", Ack1, Ack2); end
        step(2);
        checks++; if (Q !== 2'b10 || Ack1 !== 1'b1 || Ack2 !== 1'b0) begin failures++; $display("FAIL pair2_second: q=%b ack1=%b ack2=%b expected 10 1 0", Q, Ack1, Ack2); end
        Req1 = 1'b0;
        step(2);
        $display("test_pair done: q=%b", Q);
    endtask

    task automatic test_regrant;
        Req2 = 1'b1; Op2 = 2'b11;
        step(2);
        checks++; if (Q !== 2'b01 || Ack2 !== 1'b1) begin failures++; $display("FAIL regrant_first: q=%b ack2=%b expected 01 1", Q, Ack2); end
        Req2 = 1'b0;
        step(1);
        checks++; if (Ack2 !== 1'b0) begin failures++; $display("FAIL regrant_release: ack2=%b expected 0", Ack2); end
        Req2 = 1'b1; Op2 = 2'b10;
        for (int i = 0; i < 3; i++) begin
            step(1);
            checks++; if (Ack2 !== 1'b0 || Busy !== 1'b0) begin failures++; $display("FAIL regrant_stale[%0d]: ack2=%b busy=%b expected 0 0", i, Ack2, Busy); end
        end
        Req2 = 1'b0;
        step(1);
        Req2 = 1'b1;
        step(2);
        checks++; if (Q !== 2'b00 || Ack2 !== 1'b1) begin failures++; $display("FAIL regrant_second: q=%b ack2=%b expected 00 1", Q, Ack2); end
        Req2 = 1'b0;
        step(2);
        $display("test_regrant done: q=%b", Q);
    endtask

    task automatic test_reset_grant;
        Req1 = 1'b1; Op1 = 2'b01;
        step(1);
        checks++; if (Busy !== 1'b1) begin failures++; $display("FAIL rstgrant_busy: got %b expected 1", Busy); end
        R = 1'b1;
        step(1);
        checks++; if (Q !== 2'b00 || Q_N !== 2'b11) begin failures++; $display("FAIL rstgrant_q: q=%b qn=%b expected 00 11", Q, Q_N); end
        checks++; if (Ack1 !== 1'b0 || Busy !== 1'b0) begin failures++; $display("FAIL rstgrant_state: ack1=%b busy=%b expected 0 0", Ack1, Busy); end
        R = 1'b0; Req1 = 1'b0;
        step(2);
        $display("test_reset_grant done: q=%b busy=%b", Q, Busy);
    endtask

    task automatic test_timeout;
        int ack1_cnt;
        int err_cnt;
        int ack2_at;
        ack2_at = -1;
        Req1 = 1'b1; Op1 = 2'b01;
        step(2);
        checks++; if (Ack1 !== 1'b1 || Q !== 2'b11) begin failures++; $display("FAIL timeout_grant: ack1=%b q=%b expected 1 11", Ack1, Q); end
        Req2 = 1'b1; Op2 = 2'b00; Dat2 = 2'b01;
        ack1_cnt = 1;
        err_cnt  = 0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (Ack1 === 1'b1) ack1_cnt++;
            if (Ack2 === 1'b1 && ack2_at < 0) ack2_at = i;
`ifdef DFF_PAIR_ARB_TIMEOUT_EN
            if (Err === 1'b1) err_cnt++;
`endif
        end
`ifdef DFF_PAIR_ARB_TIMEOUT_EN
        // 16 ACKW cycles, Err on the 16th edge, then IDLE and GRANT before Ack2 (loop index 17).
        checks++; if (ack1_cnt != 16) begin failures++; $display("FAIL timeout_ack1_cycles: got %0d expected 16", ack1_cnt); end
        checks++; if (err_cnt != 1) begin failures++; $display("FAIL timeout_err_cycles: got %0d expected 1", err_cnt); end
        checks++; if (ack2_at != 17) begin failures++; $display("FAIL timeout_pending: ack2 index %0d expected 17", ack2_at); end
        checks++; if (Q !== 2'b01) begin failures++; $display("FAIL timeout_q: got %b expected 01", Q); end
`else
        checks++; if (ack1_cnt != 21) begin failures++; $display("FAIL hold_ack1_cycles: got %0d expected 21", ack1_cnt); end
        checks++; if (ack2_at != -1) begin failures++; $display("FAIL hold_ack2: ack2 index %0d expected none", ack2_at); end
        checks++; if (Q !== 2'b11) begin failures++; $display("FAIL hold_q: got %b expected 11", Q); end
`endif
        Req1 = 1'b0; Req2 = 1'b0;
        step(3);
        $display("test_timeout done: ack1_cycles=%0d err_cycles=%0d ack2_at=%0d", ack1_cnt, err_cnt, ack2_at);
    endtask

    initial begin
        test_reset;
        test_load;
        test_pair;
        test_regrant;
        test_reset_grant;
        test_timeout;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
